// File: rtl/slave_turn_ctrl.sv
// Slave-side (player B) Battleship turn sequencer: owns B's ships and the attack
// history registers, checks attack legality and hands B's attack to the UART TX path.
module slave_turn_ctrl #(
  parameter int N          = 16,
  parameter int SHIP_CELLS = 7
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [N-1:0] sw,
  input  logic         btn_place,
  input  logic         btn_fire,
  input  logic         rx_valid,
  input  logic [N-1:0] rx_attack,
  input  logic         peer_dead,
  input  logic         tx_ready,
  output logic         tx_valid,
  output logic [N-1:0] tx_attack,
  output logic [N-1:0] ships,
  output logic         hit,
  output logic         live_b,
  output logic         win_b,
  output logic         ok_b,
  output logic         err_a,
  output logic         err_b,
  output logic         err_ovr,
  output logic [1:0]   disp_sel,
  output logic [2:0]   state
);

  typedef enum logic [2:0] {
    PLACE    = 3'd0,
    WAIT_A   = 3'd1,
    CHECK_A  = 3'd2,
    SELECT_B = 3'd3,
    SEND_B   = 3'd4,
    OVER     = 3'd5
  } state_t;

  state_t cur, nxt;

  logic [N-1:0] prev_a, prev_b, cand;
  logic [N-1:0] ships_after;
  logic         a_ok, b_ok, place_ok;

  // An attack vector is cumulative: it must keep every earlier shot and add exactly one.
  function automatic logic legal(input logic [N-1:0] c, input logic [N-1:0] p);
    legal = ((p & ~c) == '0) && ($countones(c & ~p) == 1);
  endfunction

  assign a_ok        = legal(cand, prev_a);
  assign b_ok        = legal(sw, prev_b);
  assign place_ok    = ($countones(sw) == SHIP_CELLS);
  assign ships_after = ships & ~cand;
  assign state       = cur;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) cur <= PLACE;
    else      cur <= nxt;
  end

  always_comb begin
    nxt      = cur;
    disp_sel = 2'd0;
    ok_b     = 1'b0;
    case (cur)
      PLACE: begin
        if (btn_place && place_ok) nxt = WAIT_A;
      end
      WAIT_A: begin
        disp_sel = 2'd2;
        if (peer_dead)     nxt = OVER;
        else if (rx_valid) nxt = CHECK_A;
      end
      CHECK_A: begin
        disp_sel = 2'd2;
        if (a_ok) nxt = (ships_after == '0) ? OVER : SELECT_B;
        else      nxt = WAIT_A;
      end
      SELECT_B: begin
        disp_sel = 2'd1;
        ok_b     = 1'b1;
        if (btn_fire && b_ok) nxt = SEND_B;
      end
      SEND_B: begin
        disp_sel = 2'd1;
        if (tx_valid && tx_ready) nxt = WAIT_A;
      end
      OVER: begin
        disp_sel = 2'd3;
        if (btn_place) nxt = PLACE;
      end
      default: nxt = PLACE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ships     <= '0;
      prev_a    <= '0;
      prev_b    <= '0;
      cand      <= '0;
      tx_attack <= '0;
      tx_valid  <= 1'b0;
      hit       <= 1'b0;
      live_b    <= 1'b1;
      win_b     <= 1'b0;
      err_a     <= 1'b0;
      err_b     <= 1'b0;
    end else begin
      err_a <= 1'b0;
      err_b <= 1'b0;
      case (cur)
        PLACE: begin
          if (btn_place) begin
            if (place_ok) begin
              ships  <= sw;
              prev_a <= '0;
              prev_b <= '0;
              live_b <= 1'b1;
            end else begin
              err_b <= 1'b1;
            end
          end
        end
        WAIT_A: begin
          if (peer_dead)     win_b <= 1'b1;
          else if (rx_valid) cand  <= rx_attack;
        end
        CHECK_A: begin
          if (a_ok) begin
            prev_a <= cand;
            hit    <= |(cand & ~prev_a & ships);
            ships  <= ships_after;
            if (ships_after == '0) live_b <= 1'b0;
          end else begin
            err_a <= 1'b1;
          end
        end
        SELECT_B: begin
          if (btn_fire) begin
            if (b_ok) begin
              tx_attack <= sw;
              prev_b    <= sw;
              tx_valid  <= 1'b1;
            end else begin
              err_b <= 1'b1;
            end
          end
        end
        SEND_B: begin
          if (tx_ready) tx_valid <= 1'b0;
        end
        OVER: begin
          if (btn_place) begin
            ships     <= '0;
            prev_a    <= '0;
            prev_b    <= '0;
            cand      <= '0;
            tx_attack <= '0;
            tx_valid  <= 1'b0;
            hit       <= 1'b0;
            live_b    <= 1'b1;
            win_b     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Overrun flag: entering PLACE clears it, even if rx_valid arrives in that same cycle.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)                                err_ovr <= 1'b0;
    else if (nxt == PLACE && cur != PLACE)   err_ovr <= 1'b0;
    else if (rx_valid && cur != WAIT_A)      err_ovr <= 1'b1;
  end

endmodule
